// File: rtl/ibex_wb_pkg.sv
// ---------------------------------------------------------------------------
// ibex_wb_pkg
// Shared types and constants for the Ibex <-> Wishbone B4 bridges.
//   wb_state_e  : bridge FSM state (IDLE, BUSY, DRAIN)
//   WB_SEL_WORD : byte selects for a full-word access
//   WB_DW/WB_AW : Wishbone data/address width
// ---------------------------------------------------------------------------
package ibex_wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

    localparam logic [3:0] WB_SEL_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/ibex_wb_watchdog.sv
// ---------------------------------------------------------------------------
// ibex_wb_watchdog
// Stall watchdog: counts enabled cycles since the last clear and raises fire
// in the cycle that would make the count reach TimeoutCycles. TimeoutCycles=0
// removes the counter and fire is tied low.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (has priority over en)
//   en         : count this cycle
//   fire       : timeout reached this cycle (combinational)
// ---------------------------------------------------------------------------
module ibex_wb_watchdog #(
    parameter int TimeoutCycles = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic fire
);

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

    generate
        if (TimeoutCycles == 0) begin : g_off
            logic unused_wd;
            assign unused_wd = clk ^ rst_n ^ clr ^ en;
            assign fire      = 1'b0;
        end else begin : g_on
            localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);
            localparam logic [CntW-1:0] CntOne  = CntW'(1);

            logic [CntW-1:0] wd_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_q <= '0;
                end else if (clr) begin
                    wd_q <= '0;
                end else if (en) begin
                    wd_q <= wd_q + CntOne;
                end
            end

            // Fires on the increment that lands on TimeoutCycles.
            assign fire = en & ~clr & (wd_q == LastCnt);
        end
    endgenerate

endmodule

// File: rtl/ibex_instr_wb_bridge.sv
// ---------------------------------------------------------------------------
// ibex_instr_wb_bridge
// Converts the Ibex instruction fetch port (req/gnt/rvalid) into a Wishbone B4
// pipelined read master. Bounds outstanding fetches to MaxOutstanding and
// returns exactly one rvalid per granted fetch; a hung slave is turned into
// error responses by the watchdog.
//
// Optional macro IBEX_INSTR_WB_RSP_REG_EN: register rvalid/err/rdata (one
// extra cycle of fetch latency). Undefined: combinational response path.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   instr_req_i/addr_i  : core fetch request and address
//   instr_gnt_o         : fetch accepted this cycle
//   instr_rvalid_o      : response valid (one per granted fetch)
//   instr_rdata_o/err_o : response data / error, qualified by rvalid
//   wb_cyc_o/stb_o      : Wishbone cycle / strobe
//   wb_adr_o/sel_o/we_o : word address, byte selects (F), write enable (0)
//   wb_stall_i/ack_i/err_i/dat_i : Wishbone slave handshake and read data
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no fetch outstanding
// BUSY  | one or more fetches outstanding on the bus
// DRAIN | watchdog fired; answer every outstanding fetch with an error
// ---------------------------------------------------------------------------
module ibex_instr_wb_bridge
    import ibex_wb_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int TimeoutCycles  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_req_i,
    input  logic [WB_AW-1:0] instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [WB_DW-1:0] instr_rdata_o,
    output logic             instr_err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [WB_AW-1:0] wb_adr_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    input  logic             wb_stall_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic [WB_DW-1:0] wb_dat_i
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    wb_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             stb;
    logic             gnt;
    logic             rsp;
    logic             rsp_err;
    logic [WB_DW-1:0] rsp_data;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_fire;
    logic             cnt_nz;
    logic             unused_addr;

    assign cnt_nz      = (cnt_q != '0);
    assign unused_addr = ^instr_addr_i[1:0];

    ibex_wb_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (wd_clr),
        .en   (wd_en),
        .fire (wd_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        stb      = 1'b0;
        gnt      = 1'b0;
        rsp      = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        wd_clr   = 1'b1;
        wd_en    = 1'b0;
        cnt_d    = cnt_q;
        state_d  = state_q;

        case (state_q)
            DRAIN: begin
                // Slave is ignored; synthesize one error response per cycle.
                rsp     = 1'b1;
                rsp_err = 1'b1;
                cnt_d   = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // rst_n gating keeps stb/gnt low while reset is asserted even
                // though they are otherwise combinational from instr_req_i.
                stb      = rst_n & instr_req_i & (cnt_q < CntMax);
                gnt      = stb & ~wb_stall_i;
                rsp      = (wb_ack_i | wb_err_i) & cnt_nz;
                rsp_err  = wb_err_i & rsp;
                rsp_data = rsp ? wb_dat_i : '0;
                cnt_d    = cnt_q + CntW'(gnt) - CntW'(rsp);
                wd_clr   = rsp | ~cnt_nz;
                wd_en    = ~wd_clr;
                if (wd_fire) begin
                    state_d = DRAIN;
                end else if (cnt_d == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
        endcase
    end

    assign wb_stb_o    = stb;
    assign instr_gnt_o = gnt;
    assign wb_cyc_o    = stb | (cnt_nz & (state_q != DRAIN));
    assign wb_adr_o    = {instr_addr_i[WB_AW-1:2], 2'b00};
    assign wb_sel_o    = WB_SEL_WORD;
    assign wb_we_o     = 1'b0;

`ifdef IBEX_INSTR_WB_RSP_REG_EN
    logic             rvalid_q;
    logic             err_q;
    logic [WB_DW-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rsp;
            err_q    <= rsp_err;
            rdata_q  <= rsp_data;
        end
    end

    assign instr_rvalid_o = rvalid_q;
    assign instr_err_o    = err_q;
    assign instr_rdata_o  = rdata_q;
`else
    assign instr_rvalid_o = rsp;
    assign instr_err_o    = rsp_err;
    assign instr_rdata_o  = rsp_data;
`endif

endmodule

// File: tb/tb_ibex_instr_wb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ibex_instr_wb_bridge
// Directed scenarios followed by random traffic, each cycle checked against a
// transaction-level model: a queue of outstanding fetches, a count of silent
// cycles, and a drain flag.
// ---------------------------------------------------------------------------
module tb_ibex_instr_wb_bridge;

    localparam int MAXO = 2;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    int tests  = 0;
    int failed = 0;

    int unsigned outstanding[$];
    int          silent;
    bit          draining;

    always #5 clk = ~clk;

    ibex_instr_wb_bridge #(
        .MaxOutstanding(MAXO),
        .TimeoutCycles (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_adr_o      (wb_adr_o),
        .wb_sel_o      (wb_sel_o),
        .wb_we_o       (wb_we_o),
        .wb_stall_i    (wb_stall_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .wb_dat_i      (wb_dat_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive inputs at the falling edge, check outputs 1ns
    // later, then advance the model past the rising edge.
    task automatic step(input bit req, input logic [31:0] addr, input bit stall,
                        input bit ack, input bit err, input logic [31:0] dat);
        bit          e_stb, e_gnt, e_rv, e_er, e_cyc;
        logic [31:0] e_rd;
        int          n;
        instr_req_i  = req;
        instr_addr_i = addr;
        wb_stall_i   = stall;
        wb_ack_i     = ack;
        wb_err_i     = err;
        wb_dat_i     = dat;
        #1;
        n = outstanding.size();
        if (draining) begin
            e_stb = 0; e_gnt = 0; e_cyc = 0;
            e_rv  = 1; e_er  = 1; e_rd  = 32'h0;
        end else begin
            e_stb = req && (n < MAXO);
            e_gnt = e_stb && !stall;
            e_rv  = (ack || err) && (n > 0);
            e_er  = e_rv && err;
            e_rd  = e_rv ? dat : 32'h0;
            e_cyc = e_stb || (n > 0);
        end
        check("stb",    {31'h0, wb_stb_o},       {31'h0, e_stb});
        check("gnt",    {31'h0, instr_gnt_o},    {31'h0, e_gnt});
        check("cyc",    {31'h0, wb_cyc_o},       {31'h0, e_cyc});
        check("rvalid", {31'h0, instr_rvalid_o}, {31'h0, e_rv});
        check("err",    {31'h0, instr_err_o},    {31'h0, e_er});
        check("rdata",  instr_rdata_o,           e_rd);
        check("sel",    {28'h0, wb_sel_o},       32'hF);
        check("we",     {31'h0, wb_we_o},        32'h0);
        if (e_stb) check("adr", wb_adr_o, addr & 32'hFFFF_FFFC);

        if (draining) begin
            void'(outstanding.pop_front());
            if (outstanding.size() == 0) draining = 0;
        end else begin
            if (e_rv)  void'(outstanding.pop_front());
            if (e_gnt) outstanding.push_back(addr);
            if (e_rv || n == 0) begin
                silent = 0;
            end else begin
                silent++;
                if (silent == TMO) begin
                    draining = 1;
                    silent   = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int drain_cycles;
        rst_n        = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1234;
        wb_stall_i   = 1'b0;
        wb_ack_i     = 1'b1;
        wb_err_i     = 1'b0;
        wb_dat_i     = 32'hFFFF_FFFF;
        silent       = 0;
        draining     = 0;
        #1;
        check("rst_stb",    {31'h0, wb_stb_o},       32'h0);
        check("rst_gnt",    {31'h0, instr_gnt_o},    32'h0);
        check("rst_cyc",    {31'h0, wb_cyc_o},       32'h0);
        check("rst_rvalid", {31'h0, instr_rvalid_o}, 32'h0);
        check("rst_err",    {31'h0, instr_err_o},    32'h0);
        check("rst_rdata",  instr_rdata_o,           32'h0);
        check("rst_sel",    {28'h0, wb_sel_o},       32'hF);
        check("rst_we",     {31'h0, wb_we_o},        32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch, misaligned address, ack one cycle later.
        step(1, 32'h0000_0083, 0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 1, 0, 32'hDEAD_BEEF);
        step(0, 32'h0, 0, 0, 0, 32'h0);

        // Three back-to-back requests, limit of two, acks delayed.
        step(1, 32'h100, 0, 0, 0, 32'h0);
        step(1, 32'h104, 0, 0, 0, 32'h0);
        step(1, 32'h108, 0, 0, 0, 32'h0);
        step(1, 32'h108, 0, 0, 0, 32'h0);
        step(1, 32'h108, 0, 1, 0, 32'h11);
        step(1, 32'h108, 0, 0, 0, 32'h0);
        step(0, 32'h0,   0, 1, 0, 32'h22);
        step(0, 32'h0,   0, 0, 0, 32'h0);
        step(0, 32'h0,   0, 1, 0, 32'h33);
        step(0, 32'h0,   0, 0, 0, 32'h0);

        // Stall for four cycles, grant on the fifth.
        for (int i = 0; i < 4; i++) step(1, 32'h200, 1, 0, 0, 32'h0);
        step(1, 32'h200, 0, 0, 0, 32'h0);
        // Grant and ack together at one outstanding, then an error response.
        step(1, 32'h204, 0, 1, 0, 32'h44);
        step(0, 32'h0,   0, 0, 1, 32'h55);
        step(0, 32'h0,   0, 0, 0, 32'h0);

        // Silent slave with two outstanding: watchdog drains with errors,
        // and an ack arriving during the drain is ignored.
        step(1, 32'h300, 0, 0, 0, 32'h0);
        step(1, 32'h304, 0, 0, 0, 32'h0);
        drain_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (draining) drain_cycles++;
            step(0, 32'h0, 0, (i == 7), 0, 32'h77);
        end
        check("drain_cycles", drain_cycles, 2);

        // Reset with two fetches outstanding.
        step(1, 32'h400, 0, 0, 0, 32'h0);
        step(1, 32'h404, 0, 0, 0, 32'h0);
        instr_req_i = 1'b1;
        wb_ack_i    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc",    {31'h0, wb_cyc_o},       32'h0);
        check("mid_rst_stb",    {31'h0, wb_stb_o},       32'h0);
        check("mid_rst_rvalid", {31'h0, instr_rvalid_o}, 32'h0);
        check("mid_rst_gnt",    {31'h0, instr_gnt_o},    32'h0);
        outstanding.delete();
        silent   = 0;
        draining = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 32'h0, 0, 1, 0, 32'h66);
        step(0, 32'h0, 0, 0, 1, 32'h67);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom);
        end
        // Let everything complete (acks plus watchdog bound it).
        for (int i = 0; i < 20; i++) step(0, 32'h0, 0, 1, 0, 32'h99);
        check("final_empty", outstanding.size(), 0);
        check("final_cyc", {31'h0, wb_cyc_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
